// File: rtl/maze_solve_ctrl.sv
// maze_solve_ctrl: sequences the optional clear phase, the BFS distance fill
// and the backtrack phase. Each phase has its own watchdog. Abort is honoured
// in any active phase. The controller keeps a sticky result status and a
// saturating count of busy cycles.
module maze_solve_ctrl #(
    parameter int CLR_EN  = 1,
    parameter int TIMEOUT = 4096,
    parameter int CYC_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             clr_done_i,
    input  logic             dist_done_i,
    input  logic             bt_done_i,
    input  logic             bt_no_path_i,
    output logic             clr_en_o,
    output logic             dist_en_o,
    output logic             bt_en_o,
    output logic             busy_o,
    output logic             path_ready_o,
    output logic             no_path_o,
    output logic             timeout_o,
    output logic             aborted_o,
    output logic [1:0]       status_o,
    output logic [1:0]       fault_phase_o,
    output logic [CYC_W-1:0] solve_cycles_o
);

    // phase_cnt only has to reach TIMEOUT-1
    localparam int PH_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit WD_EN = (TIMEOUT != 0);
    localparam logic [PH_W-1:0] PH_LAST = (TIMEOUT > 0) ? PH_W'(TIMEOUT - 1) : '0;
    localparam logic [CYC_W-1:0] CYC_MAX = {CYC_W{1'b1}};

    localparam logic [1:0] ST_NONE   = 2'd0;
    localparam logic [1:0] ST_PATH   = 2'd1;
    localparam logic [1:0] ST_NOPATH = 2'd2;
    localparam logic [1:0] ST_FAULT  = 2'd3;

    localparam logic [1:0] PH_CLR  = 2'd1;
    localparam logic [1:0] PH_DIST = 2'd2;
    localparam logic [1:0] PH_BT   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_DIST = 2'd2,
        S_BT   = 2'd3
    } state_t;

    localparam state_t S_FIRST = (CLR_EN != 0) ? S_CLR : S_DIST;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_cnt_q, phase_cnt_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [1:0]        status_q, status_d;
    logic [1:0]        fault_q, fault_d;
    logic              path_q, path_d;
    logic              nopath_q, nopath_d;
    logic              to_q, to_d;
    logic              ab_q, ab_d;

    logic              done_s;
    logic [1:0]        phase_s;
    logic              wd_hit_s;

    // Select the done input and fault code belonging to the current phase
    always_comb begin
        done_s  = 1'b0;
        phase_s = 2'd0;
        case (state_q)
            S_CLR: begin
                done_s  = clr_done_i;
                phase_s = PH_CLR;
            end
            S_DIST: begin
                done_s  = dist_done_i;
                phase_s = PH_DIST;
            end
            S_BT: begin
                done_s  = bt_done_i;
                phase_s = PH_BT;
            end
            default: begin
                done_s  = 1'b0;
                phase_s = 2'd0;
            end
        endcase
    end

    assign wd_hit_s = WD_EN && (phase_cnt_q == PH_LAST);

    // Next-state, watchdog, result and cycle-count logic (abort > done > timeout)
    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q + PH_W'(1);
        cyc_d       = cyc_q;
        status_d    = status_q;
        fault_d     = fault_q;
        path_d      = 1'b0;
        nopath_d    = 1'b0;
        to_d        = 1'b0;
        ab_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                phase_cnt_d = '0;
                if (start_i) begin
                    state_d  = S_FIRST;
                    status_d = ST_NONE;
                    fault_d  = 2'd0;
                    cyc_d    = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLR, S_DIST, S_BT: begin
                cyc_d = (cyc_q == CYC_MAX) ? CYC_MAX : (cyc_q + CYC_W'(1));
                if (abort_i) begin
                    state_d     = S_IDLE;
                    phase_cnt_d = '0;
                    ab_d        = 1'b1;
                    status_d    = ST_FAULT;
                    fault_d     = phase_s;
                end else if (done_s) begin
                    phase_cnt_d = '0;
                    if (state_q == S_BT) begin
                        state_d = S_IDLE;
                        if (bt_no_path_i) begin
                            nopath_d = 1'b1;
                            status_d = ST_NOPATH;
                        end else begin
                            path_d   = 1'b1;
                            status_d = ST_PATH;
                        end
                    end else if (state_q == S_CLR) begin
                        state_d = S_DIST;
                    end else begin
                        state_d = S_BT;
                    end
                end else if (wd_hit_s) begin
                    state_d     = S_IDLE;
                    phase_cnt_d = '0;
                    to_d        = 1'b1;
                    status_d    = ST_FAULT;
                    fault_d     = phase_s;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d     = S_IDLE;
                phase_cnt_d = '0;
            end
        endcase
    end

    // State, counters, sticky status and registered result pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phase_cnt_q <= '0;
            cyc_q       <= '0;
            status_q    <= ST_NONE;
            fault_q     <= 2'd0;
            path_q      <= 1'b0;
            nopath_q    <= 1'b0;
            to_q        <= 1'b0;
            ab_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            cyc_q       <= cyc_d;
            status_q    <= status_d;
            fault_q     <= fault_d;
            path_q      <= path_d;
            nopath_q    <= nopath_d;
            to_q        <= to_d;
            ab_q        <= ab_d;
        end
    end

    assign clr_en_o       = (state_q == S_CLR);
    assign dist_en_o      = (state_q == S_DIST);
    assign bt_en_o        = (state_q == S_BT);
    assign busy_o         = (state_q != S_IDLE);
    assign path_ready_o   = path_q;
    assign no_path_o      = nopath_q;
    assign timeout_o      = to_q;
    assign aborted_o      = ab_q;
    assign status_o       = status_q;
    assign fault_phase_o  = fault_q;
    assign solve_cycles_o = cyc_q;

endmodule

// File: tb/tb_maze_solve_ctrl.sv
// Bench for maze_solve_ctrl: two instances (A: clear phase, TIMEOUT=8,
// 16-bit counter; B: no clear phase, TIMEOUT=12, 3-bit counter) share one
// stimulus stream and are compared every cycle against a phase-level model.
module tb_maze_solve_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, abort = 1'b0, clr_done = 1'b0, dist_done = 1'b0;
    logic bt_done = 1'b0, bt_no_path = 1'b0;

    logic ce_a, de_a, be_a, bz_a, pr_a, np_a, to_a, ab_a;
    logic [1:0] st_a, fp_a;
    logic [15:0] cy_a;
    logic ce_b, de_b, be_b, bz_b, pr_b, np_b, to_b, ab_b;
    logic [1:0] st_b, fp_b;
    logic [2:0] cy_b;

    int n_checks = 0;
    int n_fail = 0;

    // model: phase 0 idle, 1 clear, 2 distance, 3 backtrack
    int p_clr [2] = '{1, 0};
    int p_to  [2] = '{8, 12};
    int p_max [2] = '{65535, 7};
    int m_ph [2], m_el [2], m_st [2], m_fp [2], m_cy [2];
    bit m_pr [2], m_np [2], m_to [2], m_ab [2];

    always #5 clk = ~clk;

    maze_solve_ctrl #(.CLR_EN(1), .TIMEOUT(8), .CYC_W(16)) dut_a (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
        .clr_done_i(clr_done), .dist_done_i(dist_done), .bt_done_i(bt_done),
        .bt_no_path_i(bt_no_path),
        .clr_en_o(ce_a), .dist_en_o(de_a), .bt_en_o(be_a), .busy_o(bz_a),
        .path_ready_o(pr_a), .no_path_o(np_a), .timeout_o(to_a), .aborted_o(ab_a),
        .status_o(st_a), .fault_phase_o(fp_a), .solve_cycles_o(cy_a)
    );

    maze_solve_ctrl #(.CLR_EN(0), .TIMEOUT(12), .CYC_W(3)) dut_b (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
        .clr_done_i(clr_done), .dist_done_i(dist_done), .bt_done_i(bt_done),
        .bt_no_path_i(bt_no_path),
        .clr_en_o(ce_b), .dist_en_o(de_b), .bt_en_o(be_b), .busy_o(bz_b),
        .path_ready_o(pr_b), .no_path_o(np_b), .timeout_o(to_b), .aborted_o(ab_b),
        .status_o(st_b), .fault_phase_o(fp_b), .solve_cycles_o(cy_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = 0; m_el[i] = 0; m_st[i] = 0; m_fp[i] = 0; m_cy[i] = 0;
            m_pr[i] = 0; m_np[i] = 0; m_to[i] = 0; m_ab[i] = 0;
        end
    endtask

    // one clock edge of the reference behaviour for instance i
    task automatic model_edge(input int i);
        bit dn;
        m_pr[i] = 0; m_np[i] = 0; m_to[i] = 0; m_ab[i] = 0;
        if (m_ph[i] == 0) begin
            if (start) begin
                m_ph[i] = (p_clr[i] != 0) ? 1 : 2;
                m_el[i] = 0; m_st[i] = 0; m_fp[i] = 0; m_cy[i] = 0;
            end
        end else begin
            m_cy[i] = (m_cy[i] + 1 > p_max[i]) ? p_max[i] : m_cy[i] + 1;
            dn = (m_ph[i] == 1) ? clr_done : (m_ph[i] == 2) ? dist_done : bt_done;
            if (abort) begin
                m_ab[i] = 1; m_st[i] = 3; m_fp[i] = m_ph[i]; m_ph[i] = 0;
            end else if (dn) begin
                if (m_ph[i] == 3) begin
                    if (bt_no_path) begin m_np[i] = 1; m_st[i] = 2; end
                    else begin m_pr[i] = 1; m_st[i] = 1; end
                    m_ph[i] = 0;
                end else begin
                    m_ph[i] = m_ph[i] + 1;
                end
                m_el[i] = 0;
            end else if (p_to[i] != 0 && m_el[i] == p_to[i] - 1) begin
                m_to[i] = 1; m_st[i] = 3; m_fp[i] = m_ph[i]; m_ph[i] = 0;
            end else begin
                m_el[i] = m_el[i] + 1;
            end
        end
    endtask

    function automatic logic [7:0] exp_ctl(input int i);
        return {m_ph[i] == 1, m_ph[i] == 2, m_ph[i] == 3, m_ph[i] != 0,
                m_pr[i], m_np[i], m_to[i], m_ab[i]};
    endfunction

    task automatic compare_all();
        check_eq("a_ctl", {ce_a, de_a, be_a, bz_a, pr_a, np_a, to_a, ab_a}, exp_ctl(0));
        check_eq("a_status", st_a, m_st[0]);
        check_eq("a_fault", fp_a, m_fp[0]);
        check_eq("a_cycles", cy_a, m_cy[0]);
        check_eq("b_ctl", {ce_b, de_b, be_b, bz_b, pr_b, np_b, to_b, ab_b}, exp_ctl(1));
        check_eq("b_status", st_b, m_st[1]);
        check_eq("b_fault", fp_b, m_fp[1]);
        check_eq("b_cycles", cy_b, m_cy[1]);
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge(0);
            model_edge(1);
            #1;
            compare_all();
        end
    endtask

    task automatic set_in(input logic s, input logic a, input logic c,
                          input logic d, input logic b, input logic np);
        start = s; abort = a; clr_done = c; dist_done = d; bt_done = b; bt_no_path = np;
    endtask

    initial begin
        model_reset();
        #1;
        check_eq("rst_ctl_a", {ce_a, de_a, be_a, bz_a, pr_a, np_a, to_a, ab_a}, 8'h00);
        check_eq("rst_cyc_a", cy_a, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(2);

        // path found: clear done in cycle 2, distance done in cycle 3, bt in cycle 1
        set_in(1, 0, 0, 0, 0, 0); step(1);
        set_in(0, 0, 0, 0, 0, 0); step(1);
        set_in(0, 0, 1, 0, 0, 0); step(1);
        set_in(0, 0, 0, 0, 0, 0); step(2);
        set_in(0, 0, 0, 1, 0, 0); step(1);
        set_in(0, 0, 0, 0, 1, 0); step(1);
        check_eq("t1_path_ready", pr_a, 32'd1);
        check_eq("t1_status", st_a, 32'd1);
        check_eq("t1_cycles", cy_a, 32'd6);
        set_in(0, 0, 0, 0, 0, 0); step(2);

        // no clear phase, unreachable goal (instance B), then abort A out of CLR
        set_in(1, 0, 0, 0, 0, 0); step(1);
        set_in(0, 0, 0, 1, 0, 0); step(1);
        set_in(0, 0, 0, 0, 1, 1); step(1);
        check_eq("t2_no_path", np_b, 32'd1);
        check_eq("t2_status", st_b, 32'd2);
        check_eq("t2_cycles", cy_b, 32'd2);
        set_in(0, 1, 0, 0, 0, 0); step(1);
        check_eq("t2_abort_clr", {ab_a, st_a, fp_a}, {1'b1, 2'd3, 2'd1});
        set_in(0, 0, 0, 0, 0, 0); step(1);

        // distance phase watchdog on A: exactly 8 cycles
        set_in(1, 0, 0, 0, 0, 0); step(1);
        set_in(0, 0, 1, 0, 0, 0); step(1);
        set_in(0, 0, 0, 0, 0, 0); step(7);
        check_eq("t3_dist_c8", de_a, 32'd1);
        step(1);
        check_eq("t3_timeout", {to_a, bz_a, st_a, fp_a}, {1'b1, 1'b0, 2'd3, 2'd2});
        set_in(0, 1, 0, 0, 0, 0); step(1);
        set_in(0, 0, 0, 0, 0, 0); step(1);

        // done on the watchdog's last cycle wins; abort beats bt_done
        set_in(1, 0, 0, 0, 0, 0); step(1);
        set_in(1, 0, 1, 0, 0, 0); step(1);
        set_in(0, 0, 0, 0, 1, 0); step(7);
        set_in(0, 0, 0, 1, 0, 0); step(1);
        check_eq("t4_bt_entered", {be_a, to_a}, {1'b1, 1'b0});
        set_in(0, 1, 0, 0, 1, 0); step(1);
        check_eq("t4_abort_bt", {ab_a, pr_a, st_a, fp_a}, {1'b1, 1'b0, 2'd3, 2'd3});
        set_in(0, 1, 0, 0, 0, 0); step(2);

        // 10-cycle solve saturates B's 3-bit counter
        set_in(1, 0, 0, 0, 0, 0); step(1);
        set_in(0, 0, 0, 0, 0, 0); step(8);
        set_in(0, 0, 0, 1, 0, 0); step(1);
        set_in(0, 0, 0, 0, 1, 0); step(1);
        check_eq("t5_sat", {pr_b, cy_b}, {1'b1, 3'd7});
        set_in(0, 0, 0, 0, 0, 0); step(1);

        // asynchronous reset mid-DIST
        set_in(1, 0, 0, 0, 0, 0); step(1);
        set_in(0, 0, 1, 0, 0, 0); step(1);
        set_in(0, 0, 0, 0, 0, 0); step(2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_a", {ce_a, de_a, be_a, bz_a, pr_a, np_a, to_a, ab_a, st_a, fp_a}, 12'h000);
        check_eq("rst_mid_cyc", {cy_a, 13'd0, cy_b}, 32'd0);
        check_eq("rst_mid_b", {bz_b, st_b, fp_b}, 5'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        // minimum solve after reset: 3 busy cycles on A
        set_in(1, 0, 0, 0, 0, 0); step(1);
        set_in(0, 0, 1, 0, 0, 0); step(1);
        set_in(0, 0, 0, 1, 0, 0); step(1);
        set_in(0, 0, 0, 0, 1, 0); step(1);
        check_eq("t6_min_solve", {pr_a, cy_a}, {1'b1, 16'd3});

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            set_in($urandom_range(99) < 30, $urandom_range(99) < 3,
                   $urandom_range(99) < 25, $urandom_range(99) < 25,
                   $urandom_range(99) < 25, $urandom_range(1) == 1);
            step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
